// File: rtl/mem_responder.sv
// Unified 16-bit instruction/data store for a single-port CPU memory interface.
// The store is boot-loaded while the CPU is held, then serves registered reads and writes.
module mem_responder #(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter bit LOAD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mem_addr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_data,
  input  logic        ld_done,
  output logic        cpu_hold,
  output logic        mem_err
);

  typedef enum logic {
    ST_LOAD,
    ST_RUN
  } state_t;

  localparam state_t      RESET_STATE = LOAD_EN ? ST_LOAD : ST_RUN;
  localparam logic [16:0] DEPTH_L     = 17'(DEPTH);

  state_t state, state_nxt;

  logic [15:0] mem [DEPTH];

  logic              cpu_in_range, ld_in_range;
  logic              we, rd_en, rd_zero, err_set;
  logic [ADDR_W-1:0] waddr;
  logic [15:0]       wdata;

  // Range checks use the full 16-bit address so aliases above DEPTH are rejected.
  assign cpu_in_range = {1'b0, mem_addr} < DEPTH_L;
  assign ld_in_range  = {1'b0, ld_addr}  < DEPTH_L;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RESET_STATE;
    else       state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no latch can be inferred.
  always_comb begin
    state_nxt = state;
    if (state == ST_LOAD && ld_done) state_nxt = ST_RUN;
  end

  always_comb begin
    ld_ready = (state == ST_LOAD);
    cpu_hold = (state == ST_LOAD);
  end

  // Single write port shared by the loader (LOAD) and the CPU (RUN).
  always_comb begin
    we      = 1'b0;
    waddr   = mem_addr[ADDR_W-1:0];
    wdata   = mem_wdata;
    rd_en   = 1'b0;
    rd_zero = 1'b0;
    err_set = 1'b0;
    if (state == ST_LOAD) begin
      if (ld_valid) begin
        if (ld_in_range) begin
          we    = 1'b1;
          waddr = ld_addr[ADDR_W-1:0];
          wdata = ld_data;
        end else begin
          err_set = 1'b1;
        end
      end
    end else begin
      if (mem_write) begin
        if (cpu_in_range) we = 1'b1;
        else              err_set = 1'b1;
      end
      if (mem_read && mem_write) begin
        err_set = 1'b1;
      end else if (mem_read) begin
        if (cpu_in_range) begin
          rd_en = 1'b1;
        end else begin
          rd_zero = 1'b1;
          err_set = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rdata <= '0;
      mem_err   <= 1'b0;
    end else begin
      if (err_set) mem_err <= 1'b1;
      if (rd_en)        mem_rdata <= mem[mem_addr[ADDR_W-1:0]];
      else if (rd_zero) mem_rdata <= '0;
    end
  end

  // NOTE: the array has no reset so it maps onto RAM and keeps boot contents across a reset.
  always_ff @(posedge clk) begin
    if (we && !reset) mem[waddr] <= wdata;
  end

endmodule
